// File: rtl/nios_system_pio_pkg.sv
// Shared constants for the Nios II PIO slaves: Avalon word addresses and
// edge-capture mode encodings.
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_system_pio_sync.sv
// Multi-stage synchroniser bringing an asynchronous bus into the clk domain.
// The last stage is the only one the rest of the design may look at.
module nios_system_pio_sync #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain: stage 0 samples the raw input, later stages resolve metastability.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/nios_system_pio_in_irq.sv
// Input PIO with per-bit edge capture, interrupt mask and a level IRQ,
// exposed on an Avalon-MM slave with one cycle of read latency.
module nios_system_pio_in_irq
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int EDGE_MODE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] data_in_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] rd_word_s;
    logic             wr_s;
    logic             unused_wdata_s;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q,      irq_d;

    nios_system_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (data_in_s)
    );

    assign wr_s           = chipselect & ~write_n;
    assign wdata_s        = writedata[WIDTH-1:0];
    assign unused_wdata_s = ^writedata;
    assign rise_s         = data_in_s & ~prev_q;
    assign fall_s         = ~data_in_s & prev_q;

    // Edge qualifier selected at elaboration time.
    always_comb begin
        edge_s = '0;
        case (EDGE_MODE)
            EDGE_RISING:  edge_s = rise_s;
            EDGE_FALLING: edge_s = fall_s;
            EDGE_ANY:     edge_s = rise_s | fall_s;
            default:      edge_s = rise_s;
        endcase
    end

    // Register next-state: a new edge beats a same-cycle write-1-to-clear.
    always_comb begin
        edgecap_d = edgecap_q | edge_s;
        irqmask_d = irqmask_q;
        if (wr_s && (address == ADDR_EDGECAP)) begin
            edgecap_d = (edgecap_q & ~wdata_s) | edge_s;
        end else begin
            edgecap_d = edgecap_q | edge_s;
        end
        if (wr_s && (address == ADDR_IRQMASK)) begin
            irqmask_d = wdata_s;
        end else begin
            irqmask_d = irqmask_q;
        end
        irq_d = |(edgecap_q & irqmask_q);
    end

    // Read mux, sampled every cycle regardless of chipselect; upper bits stay zero.
    always_comb begin
        rd_word_s = '0;
        case (address)
            ADDR_DATA:    rd_word_s = data_in_s;
            ADDR_RSVD:    rd_word_s = '0;
            ADDR_IRQMASK: rd_word_s = irqmask_q;
            ADDR_EDGECAP: rd_word_s = edgecap_q;
            default:      rd_word_s = '0;
        endcase
        readdata_d               = 32'd0;
        readdata_d[WIDTH-1:0]    = rd_word_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= data_in_s;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_pio_in_irq.sv
// Bench: three DUTs (rising/falling/any) on one shared bus and input,
// compared every cycle against a sample-history reference model.
module tb_nios_system_pio_in_irq;

    localparam int W    = 4;
    localparam int SYNC = 2;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] rd_out [3];
    logic        irq_out [3];

    int n_checks = 0;
    int n_errs   = 0;

    nios_system_pio_in_irq #(.WIDTH(W), .EDGE_MODE(0), .SYNC_STAGES(SYNC)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_out[0]), .irq(irq_out[0]));

    nios_system_pio_in_irq #(.WIDTH(W), .EDGE_MODE(1), .SYNC_STAGES(SYNC)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_out[1]), .irq(irq_out[1]));

    nios_system_pio_in_irq #(.WIDTH(W), .EDGE_MODE(2), .SYNC_STAGES(SYNC)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_out[2]), .irq(irq_out[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_edge(input int mode, input logic [W-1:0] cur,
                                                input logic [W-1:0] prv);
        logic [W-1:0] r;
        logic [W-1:0] f;
        r = cur & ~prv;
        f = ~cur & prv;
        if (mode == 0)      return r;
        else if (mode == 1) return f;
        else                return r | f;
    endfunction

    // Reference model: m_smp[k] is the in_port sample taken k edges ago, so the
    // synchronised value is the sample SYNC-1 edges old and "prev" is one older.
    logic [W-1:0] m_smp [SYNC+1];
    logic [W-1:0] m_cap [3];
    logic [W-1:0] m_mask [3];
    logic [31:0]  m_rd [3];
    logic         m_irq [3];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= SYNC; k++) m_smp[k] <= '0;
            for (int m = 0; m < 3; m++) begin
                m_cap[m]  <= '0;
                m_mask[m] <= '0;
                m_rd[m]   <= 32'd0;
                m_irq[m]  <= 1'b0;
            end
        end else begin
            for (int m = 0; m < 3; m++) begin
                case (address)
                    2'd0:    m_rd[m] <= {28'd0, m_smp[SYNC-1]};
                    2'd2:    m_rd[m] <= {28'd0, m_mask[m]};
                    2'd3:    m_rd[m] <= {28'd0, m_cap[m]};
                    default: m_rd[m] <= 32'd0;
                endcase
                m_irq[m] <= |(m_cap[m] & m_mask[m]);
                if (chipselect && !write_n && address == 2'd3)
                    m_cap[m] <= (m_cap[m] & ~writedata[W-1:0]) |
                                model_edge(m, m_smp[SYNC-1], m_smp[SYNC]);
                else
                    m_cap[m] <= m_cap[m] | model_edge(m, m_smp[SYNC-1], m_smp[SYNC]);
                if (chipselect && !write_n && address == 2'd2)
                    m_mask[m] <= writedata[W-1:0];
            end
            m_smp[0] <= in_port;
            for (int k = 1; k <= SYNC; k++) m_smp[k] <= m_smp[k-1];
        end
    end

    // Continuous comparison of every DUT against the model, away from the active edge.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("model_rd_m%0d", m), rd_out[m], m_rd[m]);
            chk($sformatf("model_irq_m%0d", m), {31'd0, irq_out[m]}, {31'd0, m_irq[m]});
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] r0,
                          output logic [31:0] r1, output logic [31:0] r2);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        r0 = rd_out[0];
        r1 = rd_out[1];
        r2 = rd_out[2];
        chipselect = 1'b0;
    endtask

    logic [31:0] r0, r1, r2;

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset values on every address.
        for (int a = 0; a < 4; a++) begin
            bus_rd(a[1:0], r0, r1, r2);
            chk("reset_rd", r0, 32'd0);
        end
        chk("reset_irq", {31'd0, irq_out[0]}, 32'd0);

        // Rising edges on bits 0 and 2, mask still zero.
        in_port = 4'b0101;
        repeat (5) @(negedge clk);
        bus_rd(2'd0, r0, r1, r2);
        chk("data_0101", r0, 32'h5);
        bus_rd(2'd3, r0, r1, r2);
        chk("cap_rise", r0, 32'h5);
        chk("cap_fall_none", r1, 32'h0);
        chk("irq_unmasked0", {31'd0, irq_out[0]}, 32'd0);

        // Unmask bit 2, then clear it.
        bus_wr(2'd2, 32'h4);
        @(negedge clk);
        chk("irq_after_mask", {31'd0, irq_out[0]}, 32'd1);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3, r0, r1, r2);
        chk("cap_after_clr", r0, 32'h1);
        chk("irq_after_clr", {31'd0, irq_out[0]}, 32'd0);

        // Rise on bit 1 lands on the same edge as its write-1-to-clear.
        in_port = 4'b0111;
        repeat (2) @(negedge clk);
        bus_wr(2'd3, 32'h2);
        bus_rd(2'd3, r0, r1, r2);
        chk("set_beats_clr", r0, 32'h3);

        // Falling mode.
        in_port = 4'b1111;
        repeat (5) @(negedge clk);
        bus_wr(2'd3, 32'hF);
        in_port = 4'b1110;
        repeat (5) @(negedge clk);
        bus_rd(2'd3, r0, r1, r2);
        chk("cap_falling", r1, 32'h1);

        // Any-edge mode: bit 3 toggles twice, captured once.
        bus_wr(2'd3, 32'hF);
        in_port = 4'b0110;
        repeat (3) @(negedge clk);
        in_port = 4'b1110;
        repeat (5) @(negedge clk);
        bus_rd(2'd3, r0, r1, r2);
        chk("cap_any_bit3", r2, 32'h8);

        // Async reset while irq is high; input held through release.
        bus_wr(2'd2, 32'hF);
        @(negedge clk);
        chk("irq_before_rst", {31'd0, irq_out[0]}, 32'd1);
        in_port = 4'b0011;
        address = 2'd3;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_irq", {31'd0, irq_out[0]}, 32'd0);
        chk("rst_async_rd", rd_out[0], 32'd0);
        @(negedge clk);
        bus_rd(2'd2, r0, r1, r2);
        chk("rst_mask", r0, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_rd(2'd3, r0, r1, r2);
        chk("cap_after_release", r0, 32'h3);
        chk("cap_fall_release", r1, 32'h0);

        // Randomised traffic, checked only through the model.
        for (int i = 0; i < 600; i++) begin
            int op;
            if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: bus_rd(2'($urandom), r0, r1, r2);
                2:    bus_wr(2'd2, $urandom);
                3:    bus_wr(2'd3, $urandom);
                4:    bus_wr(2'($urandom_range(0, 1)), $urandom);
                default: @(negedge clk);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
